video_background: RTL and testbench
===================================

# video_background

Background pixel pipeline for the PPU. It captures the nametable, attribute and pattern bytes returned on the PPU bus during the fetch slots that `video_address` addresses, and loads them into 16-bit tile shifters. Each dot it emits a 4-bit background pixel (palette select + pattern bits) chosen by fine-X. It sits directly downstream of `video_address` and upstream of the pixel mux / palette lookup.

## Interface
Parameters: none.

- `I_clock` in 1: PPU dot clock.
- `I_reset` in 1: asynchronous, active-low reset.
- `I_control` in 16: sequencer strobes, bit indices from `video_control_signals`; bits are independent and may be simultaneous.
- `I_ppumask` in 8: PPUMASK. Bit 1 is show-left-8 BG, bit 3 is BG enable, bit 4 is sprite enable.
- `I_vid_fine` in 3: fine-X scroll, taken from `video_address`.
- `I_vid_addr` in 14: current PPU bus address, taken from `video_address`.
- `I_vid_data` in 8: PPU bus read data.
- `O_bg_pixel` out 4: {attr[1:0], pat_hi, pat_lo}. A value of 0 is transparent.

## Operation
- `rendering = I_ppumask[3] | I_ppumask[4]`. When it is 0, all strobes are ignored and latches and shifters hold their values.
- On `video_fetch_nt_byte_data`: latch `quad = {I_vid_addr[6], I_vid_addr[1]}` (coarse-Y bit 1, coarse-X bit 1 of the NT address).
- On `video_fetch_at_byte_data`: `at_latch = I_vid_data >> (2*quad)`, keeping bits [1:0].
- On `video_fetch_tile_lo_data`: `lo_latch = I_vid_data`.
- On `video_fetch_tile_hi_data`: `hi_latch = I_vid_data`.
- Shifters: `pat_lo_sr`, `pat_hi_sr`, `at_lo_sr`, `at_hi_sr`, each 16 bits, shifting MSB-first (left).
- `video_shift_bg`: each shifter becomes `{sr[14:0], 1'b0}`.
- `video_reload_bg`: bits [7:0] are replaced with `lo_latch`, `hi_latch`, `{8{at_latch[0]}}` and `{8{at_latch[1]}}` respectively.
- Shift and reload asserted together: shift first, then the low byte is replaced. The result is `{sr[14:7], latch}`.
- A latch strobe in the same cycle as a reload: the reload uses the old latch value.
- Pixel selection: `s = 15 - I_vid_fine`. The raw pixel is `{at_hi_sr[s], at_lo_sr[s], pat_hi_sr[s], pat_lo_sr[s]}`.
- `O_bg_pixel` is forced to 0 in each of these cases:
  - `I_ppumask[3] == 0`;
  - `video_pixel_left8` is high and `I_ppumask[1] == 0` (only when clipping is compiled in);
  - `video_pixel_visible` is low.

## Timing
- Reset: all latches, shifters, `quad` and `O_bg_pixel` are 0.
- All captures are at the rising edge on which the strobe is high. Data must be valid on `I_vid_data` in that same cycle.
- `O_bg_pixel` is registered. It reflects the shifter state, `I_vid_fine` and the qualifiers sampled at the edge, so latency is 1 cycle from those inputs.
- A reload becomes visible at the output once 8 shifts have moved the reloaded byte into bits [15:8]. This gives the two-tile prefetch depth.
- A fine-X change takes effect on the next output edge. There is no glitch protection.
- Reset mid-line: everything clears immediately and the output is 0 until a reload followed by shifts.

## Configuration
- `VIDEO_BG_LEFT_CLIP_EN` defined: the `video_pixel_left8` / `I_ppumask[1]` clip is applied.
- Not defined: the left-8 clip logic is removed and `video_pixel_left8` is ignored. The pixel is gated only by BG enable and visibility.

## Structure
- Add the bit indices `video_fetch_at_byte_data`, `video_fetch_tile_lo_data`, `video_fetch_tile_hi_data`, `video_shift_bg`, `video_reload_bg`, `video_pixel_left8` and `video_pixel_visible` to the `video_control_signals` package, beside the existing fetch indices.
- Sub-module `video_bg_shifter`: one 16-bit shift/reload register with shift, load and 8-bit load-data inputs. It is instantiated four times.
- The pixel select and gating stay in the top module.

## Test plan
- Reset: drive `I_reset` low mid-stream → `O_bg_pixel = 0`, and the shifters are 0 on release.
- Attribute quadrant: NT strobe with `I_vid_addr = 14'h2042` (quad = `2'b11`), then AT data `8'hC0` → `at_latch = 2'b11`. Repeat with addr `14'h2000` and data `8'h03` → `2'b11`.
- Full tile: mask = `8'h0A`, visible high. Load lo = `8'h80`, hi = `8'h00`, at = 1, reload, then 8 shifts with fine = 0 → the next cycle outputs `4'b0101`, followed by seven outputs of `4'b0100`.
- Fine-X: same load with fine = 3 → the `4'b0101` pixel appears 3 output cycles earlier.
- Simultaneous shift + reload with old sr = `16'hFFFF` and latch `8'h00` → sr = `16'hFF00`.
- Clipping: mask[1] = 0 with `left8` high → output 0. With `VIDEO_BG_LEFT_CLIP_EN` undefined → the raw pixel passes. With mask = `8'h00`, strobes are ignored and the latches hold.

Source files
------------

// File: rtl/video_control_signals.sv
// video_control_signals: bit indices into the 16-bit sequencer strobe word
// that the PPU timing sequencer drives to the video datapath blocks.
// Each index names one strobe. Strobes are independent of each other, and
// several may be high in the same dot.
// Ports: none (package only).
package video_control_signals;

  // Fetch slots: address phase (even) and data phase (odd).
  localparam int video_fetch_nt_byte_addr  = 0;
  localparam int video_fetch_nt_byte_data  = 1;
  localparam int video_fetch_at_byte_addr  = 2;
  localparam int video_fetch_at_byte_data  = 3;
  localparam int video_fetch_tile_lo_addr  = 4;
  localparam int video_fetch_tile_lo_data  = 5;
  localparam int video_fetch_tile_hi_addr  = 6;
  localparam int video_fetch_tile_hi_data  = 7;

  // Background shifter control and pixel qualifiers.
  localparam int video_shift_bg            = 8;
  localparam int video_reload_bg           = 9;
  localparam int video_pixel_left8         = 10;
  localparam int video_pixel_visible       = 11;

  localparam int video_control_width       = 16;

  typedef logic [video_control_width-1:0] video_control_t;
  typedef logic [3:0]                     bg_pixel_t;

  // Shift-then-reload result for one 16-bit tile shifter.
  // With both operations the low byte is replaced after the shift,
  // which leaves {sr[14:7], data}.
  function automatic logic [15:0] bg_shift_load(input logic [15:0] sr,
                                                input logic        shift,
                                                input logic        load,
                                                input logic [7:0]  data);
    logic [15:0] v;
    v = shift ? {sr[14:0], 1'b0} : sr;
    if (load) begin
      v = {v[15:8], data};
    end
    return v;
  endfunction

endpackage

// File: rtl/video_bg_shifter.sv
// video_bg_shifter: one 16-bit background tile shifter. It shifts MSB-first
// (left). A load replaces bits [7:0] with load_data. When shift and load
// are asserted together, the shift happens first.
// Ports:
//   clock     - PPU dot clock
//   reset     - asynchronous active-low reset, clears the register
//   shift     - shift left by one, a zero enters at bit 0
//   load      - replace the low byte with load_data
//   load_data - byte loaded into bits [7:0]
//   value     - current register contents
module video_bg_shifter
  import video_control_signals::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        shift,
  input  logic        load,
  input  logic [7:0]  load_data,
  output logic [15:0] value
);

  logic [15:0] sr_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sr_reg <= 16'h0000;
    end else if (shift || load) begin
      sr_reg <= bg_shift_load(sr_reg, shift, load, load_data);
    end
  end

  assign value = sr_reg;

endmodule

// File: rtl/video_background.sv
// video_background: background pixel pipeline for the PPU.
// It captures the nametable quadrant, the attribute byte and the two pattern
// bytes during their fetch data slots. It reloads them into four 16-bit tile
// shifters and emits one registered 4-bit background pixel per dot, selected
// by fine-X.
// Ports:
//   I_clock    - PPU dot clock
//   I_reset    - asynchronous active-low reset
//   I_control  - sequencer strobes (bit indices in video_control_signals)
//   I_ppumask  - PPUMASK: [1] show left-8 BG, [3] BG enable, [4] sprite enable
//   I_vid_fine - fine-X scroll
//   I_vid_addr - current PPU bus address
//   I_vid_data - PPU bus read data
//   O_bg_pixel - {attr[1:0], pat_hi, pat_lo}, 0 = transparent
// Configuration macro: VIDEO_BG_LEFT_CLIP_EN. When it is defined, the pixel is
// blanked while video_pixel_left8 is high and I_ppumask[1] is clear. When it is
// undefined, the left-8 clip is not built.
module video_background
  import video_control_signals::*;
(
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic [15:0] I_control,
  input  logic [7:0]  I_ppumask,
  input  logic [2:0]  I_vid_fine,
  input  logic [13:0] I_vid_addr,
  input  logic [7:0]  I_vid_data,
  output logic [3:0]  O_bg_pixel
);

  // While neither BG nor sprites render, the whole fetch pipeline is frozen.
  logic rendering;
  assign rendering = I_ppumask[3] | I_ppumask[4];

  logic nt_strobe, at_strobe, lo_strobe, hi_strobe, shift_en, reload_en;
  assign nt_strobe = rendering & I_control[video_fetch_nt_byte_data];
  assign at_strobe = rendering & I_control[video_fetch_at_byte_data];
  assign lo_strobe = rendering & I_control[video_fetch_tile_lo_data];
  assign hi_strobe = rendering & I_control[video_fetch_tile_hi_data];
  assign shift_en  = rendering & I_control[video_shift_bg];
  assign reload_en = rendering & I_control[video_reload_bg];

  logic [1:0] quad_reg;
  logic [1:0] at_latch_reg;
  logic [7:0] lo_latch_reg;
  logic [7:0] hi_latch_reg;

  // The quadrant {coarse-Y bit 1, coarse-X bit 1} selects which 2-bit field
  // of the attribute byte applies to this tile.
  logic [7:0] at_shifted;
  assign at_shifted = I_vid_data >> {quad_reg, 1'b0};

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      quad_reg     <= 2'b00;
      at_latch_reg <= 2'b00;
      lo_latch_reg <= 8'h00;
      hi_latch_reg <= 8'h00;
    end else begin
      if (nt_strobe) quad_reg     <= {I_vid_addr[6], I_vid_addr[1]};
      if (at_strobe) at_latch_reg <= at_shifted[1:0];
      if (lo_strobe) lo_latch_reg <= I_vid_data;
      if (hi_strobe) hi_latch_reg <= I_vid_data;
    end
  end

  // Shifter order: 0 = pattern lo, 1 = pattern hi, 2 = attr lo, 3 = attr hi.
  // The attribute bits are replicated across a whole tile so that they stay
  // aligned with the pattern bits as both shift.
  logic [7:0]  load_data [4];
  logic [15:0] sr_value  [4];

  assign load_data[0] = lo_latch_reg;
  assign load_data[1] = hi_latch_reg;
  assign load_data[2] = {8{at_latch_reg[0]}};
  assign load_data[3] = {8{at_latch_reg[1]}};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sr
      video_bg_shifter u_sr (
        .clock     (I_clock),
        .reset     (I_reset),
        .shift     (shift_en),
        .load      (reload_en),
        .load_data (load_data[gi]),
        .value     (sr_value[gi])
      );
    end
  endgenerate

  // Fine-X picks a bit from the upper tile: a larger fine-X reads further
  // toward the incoming tile.
  logic [3:0] sel_idx;
  assign sel_idx = 4'd15 - {1'b0, I_vid_fine};

  logic [3:0] raw_pixel;
  assign raw_pixel = {sr_value[3][sel_idx], sr_value[2][sel_idx],
                      sr_value[1][sel_idx], sr_value[0][sel_idx]};

  logic pixel_enable;
  always_comb begin
    pixel_enable = I_ppumask[3] & I_control[video_pixel_visible];
`ifdef VIDEO_BG_LEFT_CLIP_EN
    if (I_control[video_pixel_left8] && !I_ppumask[1]) begin
      pixel_enable = 1'b0;
    end
`endif
  end

  logic [3:0] pixel_next;
  assign pixel_next = pixel_enable ? raw_pixel : 4'h0;

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      O_bg_pixel <= 4'h0;
    end else begin
      O_bg_pixel <= pixel_next;
    end
  end

  // Only some bits of the control word, mask and address matter to this block.
  logic unused_inputs;
  assign unused_inputs = ^{I_control, I_ppumask, I_vid_addr};

endmodule

// File: tb/tb_video_background.sv
module tb_video_background;
  import video_control_signals::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] ctrl;
  logic [7:0]  mask;
  logic [2:0]  fine;
  logic [13:0] addr;
  logic [7:0]  data;
  logic [3:0]  pix;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] NT = 16'(1) << video_fetch_nt_byte_data;
  localparam logic [15:0] AT = 16'(1) << video_fetch_at_byte_data;
  localparam logic [15:0] LO = 16'(1) << video_fetch_tile_lo_data;
  localparam logic [15:0] HI = 16'(1) << video_fetch_tile_hi_data;
  localparam logic [15:0] SH = 16'(1) << video_shift_bg;
  localparam logic [15:0] RL = 16'(1) << video_reload_bg;
  localparam logic [15:0] L8 = 16'(1) << video_pixel_left8;
  localparam logic [15:0] VI = 16'(1) << video_pixel_visible;

  video_background dut (
    .I_clock    (clk),
    .I_reset    (rst_n),
    .I_control  (ctrl),
    .I_ppumask  (mask),
    .I_vid_fine (fine),
    .I_vid_addr (addr),
    .I_vid_data (data),
    .O_bg_pixel (pix)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model. Each shifter is an integer: a shift doubles it and
  // keeps 16 bits, and a reload overwrites the low byte. The pixel is
  // bit (15 - fine) of each shifter.
  int        m_sr [4];
  int        m_quad, m_at, m_lo, m_hi;
  logic [3:0] m_pix;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_sr[i] <= 0;
      m_quad <= 0; m_at <= 0; m_lo <= 0; m_hi <= 0;
      m_pix  <= 4'h0;
    end else begin
      automatic int  s = 15 - int'(fine);
      automatic int  ld [4];
      automatic int  raw = 0;
      automatic bit  en;
      automatic bit  rend = mask[3] || mask[4];
      for (int i = 0; i < 4; i++) raw += ((m_sr[i] >> s) & 1) << i;
      en = mask[3] && ctrl[video_pixel_visible];
`ifdef VIDEO_BG_LEFT_CLIP_EN
      if (ctrl[video_pixel_left8] && !mask[1]) en = 0;
`endif
      m_pix <= en ? 4'(raw) : 4'h0;
      if (rend) begin
        ld[0] = m_lo;
        ld[1] = m_hi;
        ld[2] = (m_at & 1) ? 255 : 0;
        ld[3] = (m_at & 2) ? 255 : 0;
        if (ctrl[video_fetch_nt_byte_data]) m_quad <= int'(addr[6]) * 2 + int'(addr[1]);
        if (ctrl[video_fetch_at_byte_data]) m_at <= (int'(data) >> (2 * m_quad)) % 4;
        if (ctrl[video_fetch_tile_lo_data]) m_lo <= int'(data);
        if (ctrl[video_fetch_tile_hi_data]) m_hi <= int'(data);
        for (int i = 0; i < 4; i++) begin
          automatic int v = m_sr[i];
          if (ctrl[video_shift_bg])  v = (v * 2) % 65536;
          if (ctrl[video_reload_bg]) v = (v - (v % 256)) + ld[i];
          m_sr[i] <= v;
        end
      end
    end
  end

  // Compare the DUT against the model on every clock cycle while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (pix !== m_pix) begin
        errors++;
        $display("FAIL model t=%0t: got %h expected %h", $time, pix, m_pix);
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] exp);
    checks++;
    if (pix !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, pix, exp);
    end else begin
      $display("ok   %s: pixel %h", name, pix);
    end
  endtask

  task automatic step_raw(input logic [15:0] c);
    ctrl = c;
    @(negedge clk);
  endtask

  task automatic step(input logic [15:0] c);
    step_raw(c | VI);
  endtask

  task automatic shifts(input int n);
    repeat (n) step(SH);
  endtask

  // Fetch one tile, reload it and shift it eight times into the upper byte.
  task automatic tile(input logic [13:0] a, input logic [7:0] at_b,
                      input logic [7:0] lo_b, input logic [7:0] hi_b);
    addr = a;    step(NT);
    data = at_b; step(AT);
    data = lo_b; step(LO);
    data = hi_b; step(HI);
    step(RL);
    shifts(8);
  endtask

  initial begin
    rst_n = 1'b0; ctrl = 16'h0; mask = 8'h0A; fine = 3'd0;
    addr = 14'h2000; data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_state", 4'h0);
    rst_n = 1'b1;
    step(16'h0);

    // Full tile, fine = 0: 0101 appears after 8 shifts, then 0100 seven times.
    tile(14'h2000, 8'h01, 8'h80, 8'h00);
    step(SH); chk("tile_first", 4'b0101);
    for (int i = 0; i < 7; i++) begin
      step(SH); chk("tile_rest", 4'b0100);
    end
    shifts(2);

    // Same data with fine = 3: 0101 appears three outputs earlier.
    fine = 3'd3;
    step(RL);
    shifts(5);
    step(SH); chk("finex3_first", 4'b0101);
    shifts(12);
    fine = 3'd0;

    // Attribute quadrant selection.
    tile(14'h2042, 8'hC0, 8'h00, 8'h00); step(SH); chk("quad11_c0", 4'b1100);
    shifts(8);
    tile(14'h2000, 8'h03, 8'h00, 8'h00); step(SH); chk("quad00_03", 4'b1100);
    shifts(8);
    tile(14'h2002, 8'h0C, 8'h00, 8'h00); step(SH); chk("quad01_0c", 4'b1100);
    shifts(8);
    tile(14'h2000, 8'hC0, 8'h00, 8'h00); step(SH); chk("quad00_c0", 4'b0000);
    shifts(8);

    // Shift and reload together: FFFF with latch 00 becomes FF00.
    tile(14'h2000, 8'h00, 8'hFF, 8'h00);
    step(RL);
    data = 8'h00; step(LO);
    step(SH | RL);
    shifts(7);
    step(SH); chk("sr_bit8", 4'b0001);
    step(SH); chk("sr_bit7", 4'b0000);
    shifts(8);

    // A latch strobe in the same cycle as a reload: the reload uses the old latch.
    data = 8'hFF; step(LO | RL);
    shifts(8);
    step(SH); chk("reload_old_latch", 4'b0000);
    shifts(7);
    step(RL);
    shifts(8);
    step(SH); chk("reload_new_latch", 4'b0001);
    shifts(8);

    // Visibility gate.
    tile(14'h2000, 8'h01, 8'h80, 8'h80);
    step_raw(16'h0); chk("not_visible", 4'b0000);
    mask = 8'h08;
    step(L8);
`ifdef VIDEO_BG_LEFT_CLIP_EN
    chk("left8_clip", 4'b0000);
`else
    chk("left8_clip", 4'b0111);
`endif
    mask = 8'h0A;
    step(L8); chk("left8_shown", 4'b0111);

    // With rendering off, strobes are ignored and the latches hold.
    mask = 8'h00;
    data = 8'hFF; addr = 14'h2042;
    step(NT | AT | LO | HI | RL | SH); chk("mask_off", 4'b0000);
    mask = 8'h0A;
    step(SH);
    shifts(8);
    step(RL);
    shifts(8);
    step(SH); chk("latch_hold", 4'b0111);
    shifts(8);

    // Reset mid-line.
    tile(14'h2000, 8'h03, 8'hFF, 8'hFF);
    step(SH); chk("before_reset", 4'b1111);
    rst_n = 1'b0;
    #1 chk("reset_mid", 4'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    shifts(16);
    step(SH); chk("after_reset", 4'h0);
    step(RL);
    shifts(8);
    step(SH); chk("after_reset_reload", 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
